// File: rtl/ras_pkg.sv
// Shared types and sizing for the return-address stack.
// Optional build macro RAS_CIRCULAR_EN is consumed by return_addr_stack.sv.
package ras_pkg;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam addr_t RET_INC   = addr_t'(2);
    localparam cnt_t  DEPTH_CNT = cnt_t'(DEPTH);

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_PUSH_POP,
        OP_FLUSH
    } op_e;

    // Flush dominates; push and pop together form a replace-top operation.
    function automatic op_e decode_op(input logic flush, input logic push, input logic pop);
        if (flush)             return OP_FLUSH;
        else if (push && pop)  return OP_PUSH_POP;
        else if (push)         return OP_PUSH;
        else if (pop)          return OP_POP;
        else                   return OP_IDLE;
    endfunction

endpackage

// File: rtl/return_addr_stack_if.sv
// Decoder-side request and PC-mux-side response bundle of the return-address stack.
// The stack itself uses the slave modport; the decoder/PC logic uses master.
interface return_addr_stack_if;
    import ras_pkg::*;

    logic  flush_i;
    logic  push_i;
    addr_t call_pc_i;
    logic  pop_i;
    addr_t ret_addr_o;
    logic  ret_valid_o;
    logic  empty_o;
    logic  full_o;
    logic  overflow_o;
    logic  underflow_o;
    cnt_t  count_o;

    modport master (
        output flush_i, push_i, call_pc_i, pop_i,
        input  ret_addr_o, ret_valid_o, empty_o, full_o,
               overflow_o, underflow_o, count_o
    );

    modport slave (
        input  flush_i, push_i, call_pc_i, pop_i,
        output ret_addr_o, ret_valid_o, empty_o, full_o,
               overflow_o, underflow_o, count_o
    );

endinterface

// File: rtl/ras_mem.sv
// DEPTH x ADDR_W entry storage: one synchronous write port, one combinational read port.
module ras_mem
    import ras_pkg::*;
(
    input  logic  clk,
    input  logic  we_i,
    input  ptr_t  waddr_i,
    input  addr_t wdata_i,
    input  ptr_t  raddr_i,
    output addr_t rdata_o
);

    addr_t mem_q [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the count in the
    // controller, so clearing entries would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_addr_stack.sv
// Return-address LIFO: CALL stores call PC + 2, RET returns it one cycle later.
// Define RAS_CIRCULAR_EN to let a push while full overwrite the oldest entry.
module return_addr_stack
    import ras_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    return_addr_stack_if.slave bus
);

    // sp_q points at the next free slot; the top entry lives at sp_q - 1.
    ptr_t  sp_q, sp_d;
    cnt_t  count_q, count_d;
    addr_t ret_addr_q, ret_addr_d;
    logic  ret_valid_q, ret_valid_d;
    logic  overflow_q, overflow_d;
    logic  underflow_q, underflow_d;
    logic  empty_q, empty_d;
    logic  full_q, full_d;

    logic  mem_we;
    ptr_t  mem_waddr;
    addr_t mem_wdata;
    ptr_t  top_ptr;
    addr_t top_data;
    op_e   op;

    assign top_ptr   = sp_q - ptr_t'(1);
    assign mem_wdata = bus.call_pc_i + RET_INC;
    assign op        = decode_op(bus.flush_i, bus.push_i, bus.pop_i);

    ras_mem u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (top_ptr),
        .rdata_o (top_data)
    );

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        sp_d        = sp_q;
        count_d     = count_q;
        ret_addr_d  = ret_addr_q;
        ret_valid_d = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = sp_q;

        unique case (op)
            OP_FLUSH: begin
                sp_d    = '0;
                count_d = '0;
            end

            OP_PUSH: begin
                if (!full_q) begin
                    mem_we  = 1'b1;
                    sp_d    = sp_q + ptr_t'(1);
                    count_d = count_q + cnt_t'(1);
                end else begin
                    overflow_d = 1'b1;
`ifdef RAS_CIRCULAR_EN
                    // When full, sp_q already indexes the oldest entry.
                    mem_we = 1'b1;
                    sp_d   = sp_q + ptr_t'(1);
`endif
                end
            end

            OP_POP: begin
                if (empty_q) begin
                    underflow_d = 1'b1;
                end else begin
                    ret_addr_d  = top_data;
                    ret_valid_d = 1'b1;
                    sp_d        = top_ptr;
                    count_d     = count_q - cnt_t'(1);
                end
            end

            OP_PUSH_POP: begin
                mem_we = 1'b1;
                if (empty_q) begin
                    underflow_d = 1'b1;
                    sp_d        = sp_q + ptr_t'(1);
                    count_d     = cnt_t'(1);
                end else begin
                    ret_addr_d  = top_data;
                    ret_valid_d = 1'b1;
                    mem_waddr   = top_ptr;
                end
            end

            default: ;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_CNT);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q        <= '0;
            count_q     <= '0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
        end
    end

    assign bus.ret_addr_o  = ret_addr_q;
    assign bus.ret_valid_o = ret_valid_q;
    assign bus.overflow_o  = overflow_q;
    assign bus.underflow_o = underflow_q;
    assign bus.empty_o     = empty_q;
    assign bus.full_o      = full_q;
    assign bus.count_o     = count_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack with a queue-based reference stack and
// an expected-result scoreboard; honours RAS_CIRCULAR_EN when defined.
module tb_return_addr_stack;
    import ras_pkg::*;

    typedef struct packed {
        addr_t ret_addr;
        logic  ret_valid;
        logic  empty;
        logic  full;
        logic  overflow;
        logic  underflow;
        cnt_t  count;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exp_t  sb_q [$];
    addr_t model_stk [$];
    addr_t model_ret_addr = '0;

    return_addr_stack_if bus ();

    return_addr_stack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one cycle of the currently driven inputs.
    task automatic model_step(input logic do_rst);
        exp_t  e;
        addr_t v;
        v = bus.call_pc_i + 16'd2;
        e = '0;
        if (do_rst) begin
            model_stk.delete();
            model_ret_addr = '0;
        end else if (bus.flush_i) begin
            model_stk.delete();
        end else if (bus.push_i && bus.pop_i) begin
            if (model_stk.size() == 0) begin
                e.underflow = 1'b1;
                model_stk.push_back(v);
            end else begin
                model_ret_addr = model_stk[$];
                e.ret_valid = 1'b1;
                model_stk[model_stk.size()-1] = v;
            end
        end else if (bus.pop_i) begin
            if (model_stk.size() == 0) e.underflow = 1'b1;
            else begin
                model_ret_addr = model_stk.pop_back();
                e.ret_valid = 1'b1;
            end
        end else if (bus.push_i) begin
            if (model_stk.size() == DEPTH) begin
                e.overflow = 1'b1;
`ifdef RAS_CIRCULAR_EN
                void'(model_stk.pop_front());
                model_stk.push_back(v);
`endif
            end else begin
                model_stk.push_back(v);
            end
        end
        e.ret_addr = model_ret_addr;
        e.count    = cnt_t'(model_stk.size());
        e.empty    = (model_stk.size() == 0);
        e.full     = (model_stk.size() == DEPTH);
        sb_q.push_back(e);
    endtask

    // Drive one cycle, predict, clock, then compare the DUT against the oldest prediction.
    task automatic cycle(input string tag, input logic r, input logic fl,
                         input logic pu, input logic po, input addr_t pc);
        exp_t e;
        rst           = r;
        bus.flush_i   = fl;
        bus.push_i    = pu;
        bus.pop_i     = po;
        bus.call_pc_i = pc;
        model_step(r);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, ".ret_addr"},  32'(bus.ret_addr_o),  32'(e.ret_addr));
        check({tag, ".ret_valid"}, 32'(bus.ret_valid_o), 32'(e.ret_valid));
        check({tag, ".empty"},     32'(bus.empty_o),     32'(e.empty));
        check({tag, ".full"},      32'(bus.full_o),      32'(e.full));
        check({tag, ".overflow"},  32'(bus.overflow_o),  32'(e.overflow));
        check({tag, ".underflow"}, 32'(bus.underflow_o), 32'(e.underflow));
        check({tag, ".count"},     32'(bus.count_o),     32'(e.count));
        rst         = 1'b0;
        bus.flush_i = 1'b0;
        bus.push_i  = 1'b0;
        bus.pop_i   = 1'b0;
    endtask

    initial begin
        bus.flush_i   = 1'b0;
        bus.push_i    = 1'b0;
        bus.pop_i     = 1'b0;
        bus.call_pc_i = '0;
        #2;

        // 1: basic LIFO order
        cycle("t1_rst", 1, 0, 0, 0, 16'h0000);
        cycle("t1_push", 0, 0, 1, 0, 16'h0100);
        cycle("t1_push", 0, 0, 1, 0, 16'h0200);
        cycle("t1_push", 0, 0, 1, 0, 16'h0300);
        cycle("t1_pop0", 0, 0, 0, 1, 16'h0000);
        check("t1_pop0_addr", 32'(bus.ret_addr_o), 32'h0302);
        cycle("t1_pop1", 0, 0, 0, 1, 16'h0000);
        check("t1_pop1_addr", 32'(bus.ret_addr_o), 32'h0202);
        cycle("t1_pop2", 0, 0, 0, 1, 16'h0000);
        check("t1_pop2_addr", 32'(bus.ret_addr_o), 32'h0102);
        cycle("t1_idle", 0, 0, 0, 0, 16'h0000);

        // 2: underflow straight after reset
        cycle("t2_rst", 1, 0, 0, 0, 16'h0000);
        cycle("t2_pop", 0, 0, 0, 1, 16'h0000);
        check("t2_underflow", 32'(bus.underflow_o), 32'h1);
        cycle("t2_idle", 0, 0, 0, 0, 16'h0000);

        // 3: +2 wraps modulo 2^16
        cycle("t3_push", 0, 0, 1, 0, 16'hFFFE);
        cycle("t3_pop", 0, 0, 0, 1, 16'h0000);
        check("t3_wrap_addr", 32'(bus.ret_addr_o), 32'h0000);

        // 4: overflow on push DEPTH+1, then drain
        for (int i = 0; i <= DEPTH; i++) begin
            cycle("t4_push", 0, 0, 1, 0, addr_t'(16'h0010 * i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle("t4_pop", 0, 0, 0, 1, 16'h0000);
        end
        cycle("t4_pop_empty", 0, 0, 0, 1, 16'h0000);

        // 5: simultaneous push/pop replaces the top
        cycle("t5_push", 0, 0, 1, 0, 16'h0040);
        cycle("t5_pushpop", 0, 0, 1, 1, 16'h0080);
        check("t5_pushpop_addr", 32'(bus.ret_addr_o), 32'h0042);
        cycle("t5_pop", 0, 0, 0, 1, 16'h0000);
        check("t5_pop_addr", 32'(bus.ret_addr_o), 32'h0082);
        cycle("t5_pushpop_empty", 0, 0, 1, 1, 16'h0123);
        cycle("t5_pop_last", 0, 0, 0, 1, 16'h0000);

        // 6: flush beats pop, then reset in the middle of a push burst
        cycle("t6_push", 0, 0, 1, 0, 16'h0500);
        cycle("t6_push", 0, 0, 1, 0, 16'h0600);
        cycle("t6_push", 0, 0, 1, 0, 16'h0700);
        cycle("t6_flush", 0, 1, 0, 1, 16'h0000);
        cycle("t6_pop_after_flush", 0, 0, 0, 1, 16'h0000);
        cycle("t6_burst", 0, 0, 1, 0, 16'h0900);
        cycle("t6_burst", 0, 0, 1, 0, 16'h0A00);
        cycle("t6_pop_burst", 0, 0, 0, 1, 16'h0000);
        cycle("t6_rst_burst", 1, 0, 1, 0, 16'h0B00);
        check("t6_rst_count", 32'(bus.count_o), 32'h0);
        check("t6_rst_addr", 32'(bus.ret_addr_o), 32'h0);
        cycle("t6_after_rst", 0, 0, 1, 0, 16'h0C00);
        cycle("t6_final_pop", 0, 0, 0, 1, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
